sng_multi_ch: RTL and testbench

Parametrised multi-channel stochastic number generator. It converts N_CH unsigned WIDTH-bit binary operands into N_CH parallel unipolar bit streams, each 2^WIDTH bits long. All channels share one stream counter. Generation uses weighted-binary selection, so each stream contains exactly x ones per 2^WIDTH bits. It sits between the binary activation/weight buffers and the stochastic multiply/accumulate array, with a start/stop/done handshake toward the layer controller.

---
 rtl/sng_pkg.sv | 47 ++++
 rtl/sng_wbg_sel.sv | 31 +++
 rtl/sng_multi_ch.sv | 155 +++++++++++++++
 tb/tb_sng_multi_ch.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/sng_pkg.sv
// Shared types and helpers for the stochastic number generator.
// Holds the control state encoding, LFSR tap masks and the trailing-ones select helper.
// Everything here is pure combinational or constant.
package sng_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GEN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Fibonacci LFSR feedback masks for a left-shifting register. Bit j is set
    // when r[j] feeds the XOR. Each mask comes from a primitive polynomial, so
    // the register cycles through all 2^w-1 non-zero states.
    function automatic logic [7:0] lfsr_taps(input int w);
        logic [7:0] m;
        case (w)
            2:       m = 8'b0000_0011; // x^2+x+1
            3:       m = 8'b0000_0110; // x^3+x+1
            4:       m = 8'b0000_1100; // x^4+x+1
            5:       m = 8'b0001_0100; // x^5+x^2+1
            6:       m = 8'b0011_0000; // x^6+x+1
            7:       m = 8'b0110_0000; // x^7+x+1
            8:       m = 8'b1011_1000; // x^8+x^4+x^3+x^2+1
            default: m = 8'b0000_0000;
        endcase
        return m;
    endfunction

    // Number of consecutive ones starting at bit 0 of c, limited to w bits.
    // A result of w means c is all ones within the stream width.
    function automatic logic [3:0] trailing_ones(input logic [7:0] c, input int w);
        logic [3:0] n;
        logic       run;
        n   = 4'd0;
        run = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (run && (i < w) && c[i]) begin
                n = n + 4'd1;
            end else begin
                run = 1'b0;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/sng_wbg_sel.sv
// Weighted-binary bit selector for one channel: picks operand bit WIDTH-1-t, t = trailing ones of cnt.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the bit is meaningful.
module sng_wbg_sel
    import sng_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] cnt_i,
    output logic             sn_o
);

    logic [7:0] cnt_ext;
    logic [3:0] t;

    // Select the operand bit whose weight matches the counter's trailing-ones run;
    // the all-ones counter value matches no bit and yields zero.
    always_comb begin
        cnt_ext             = 8'd0;
        cnt_ext[WIDTH-1:0]  = cnt_i;
        t                   = trailing_ones(cnt_ext, WIDTH);
        sn_o                = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (t == 4'(i)) begin
                sn_o = x_i[WIDTH-1-i];
            end
        end
    end

endmodule

// File: rtl/sng_multi_ch.sv
// Multi-channel stochastic number generator: N_CH operands -> N_CH unipolar streams of 2^WIDTH bits.
// Latency: first stream bit one cycle after start is sampled; done pulses the cycle after the last bit.
// Backpressure: none; stop aborts a stream, build with SNG_LFSR_EN for comparator/LFSR generation.
module sng_multi_ch
    import sng_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int N_CH      = 1,
    parameter int SEED_STEP = 5
) (
    input  logic                   i_clk_sng,
    input  logic                   i_rst_sng,
    input  logic                   i_start,
    input  logic                   i_stop,
    input  logic [N_CH*WIDTH-1:0]  i_x,
    output logic [N_CH-1:0]        o_sn,
    output logic                   o_valid,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [WIDTH-1:0]       o_cnt
);

    localparam logic [WIDTH-1:0] CNT_LAST = '1;

    state_t                  state_q, state_d;
    logic [WIDTH-1:0]        cnt_q, cnt_d;
    logic [N_CH*WIDTH-1:0]   x_q, x_d;
    logic                    valid_q, valid_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [N_CH-1:0]         sn_q, sn_d;
    logic [N_CH-1:0]         bit_d;
    logic                    accept;

    // Start is honoured outside GEN only, and a simultaneous stop cancels it.
    assign accept = (state_q != GEN) && i_start && !i_stop;

    // Next-state and next-output decode; outputs are computed one cycle ahead and registered.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    state_d = GEN;
                    x_d     = i_x;
                    cnt_d   = '0;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            GEN: begin
                if (i_stop) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Stream bits are held at zero whenever no valid bit is being presented.
    assign sn_d = valid_d ? bit_d : '0;

`ifdef SNG_LFSR_EN
    localparam logic [7:0]       TAPS_ALL = lfsr_taps(WIDTH);
    localparam logic [WIDTH-1:0] TAPS     = TAPS_ALL[WIDTH-1:0];

    for (genvar k = 0; k < N_CH; k++) begin : g_lfsr
        localparam int               SEED_INT = (k * SEED_STEP + 1) % (1 << WIDTH);
        localparam logic [WIDTH-1:0] SEED     = SEED_INT[WIDTH-1:0];

        logic [WIDTH-1:0] r_q, r_d;
        logic             fb;

        // Advance the LFSR; flipping feedback on 10..0 / 00..0 splices the zero state
        // into the cycle so every value appears once per stream.
        always_comb begin
            fb  = (^(r_q & TAPS)) ^ (r_q[WIDTH-2:0] == '0);
            r_d = r_q;
            if (accept) begin
                r_d = SEED;
            end else if (state_q == GEN) begin
                r_d = {r_q[WIDTH-2:0], fb};
            end
        end

        // Per-channel random reference register.
        always_ff @(posedge i_clk_sng or posedge i_rst_sng) begin
            if (i_rst_sng) begin
                r_q <= '0;
            end else begin
                r_q <= r_d;
            end
        end

        assign bit_d[k] = (x_d[k*WIDTH +: WIDTH] > r_d);
    end
`else
    for (genvar k = 0; k < N_CH; k++) begin : g_sel
        sng_wbg_sel #(
            .WIDTH (WIDTH)
        ) u_sel (
            .x_i   (x_d[k*WIDTH +: WIDTH]),
            .cnt_i (cnt_d),
            .sn_o  (bit_d[k])
        );
    end
`endif

    // Control state, shared counter, latched operands and registered outputs.
    always_ff @(posedge i_clk_sng or posedge i_rst_sng) begin
        if (i_rst_sng) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sn_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sn_q    <= sn_d;
        end
    end

    assign o_sn    = sn_q;
    assign o_valid = valid_q;
    assign o_busy  = busy_q;
    assign o_done  = done_q;
    assign o_cnt   = cnt_q;

endmodule

// File: tb/tb_sng_multi_ch.sv
// Directed bench for sng_multi_ch: WIDTH=4, N_CH=4.
// Outputs are sampled on the falling clock edge; inputs change there too.
// Expected values are hand-derived stream patterns and ones counts.
module tb_sng_multi_ch;

    localparam int W  = 4;
    localparam int NC = 4;
    localparam int L  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              stop;
    logic [NC*W-1:0]   x;
    logic [NC-1:0]     sn;
    logic              valid;
    logic              busy;
    logic              done;
    logic [W-1:0]      cnt;

    always #5 clk = ~clk;

    sng_multi_ch #(
        .WIDTH     (W),
        .N_CH      (NC),
        .SEED_STEP (5)
    ) dut (
        .i_clk_sng (clk),
        .i_rst_sng (rst),
        .i_start   (start),
        .i_stop    (stop),
        .i_x       (x),
        .o_sn      (sn),
        .o_valid   (valid),
        .o_busy    (busy),
        .o_done    (done),
        .o_cnt     (cnt)
    );

    int          n_chk = 0;
    int          n_err = 0;
    logic [L-1:0] pat [NC];
    int          ones [NC];
    int          nvalid;
    int          ndone;
    int          done_at;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one start pulse and record the stream; stop_at >= 0 raises stop when o_cnt hits it.
    // The operand bus is scrambled after the start so latching can be observed.
    task automatic run_stream(input logic [NC*W-1:0] xv, input int stop_at);
        bit fin;
        fin     = 1'b0;
        nvalid  = 0;
        ndone   = 0;
        done_at = -1;
        for (int k = 0; k < NC; k++) begin
            pat[k]  = '0;
            ones[k] = 0;
        end
        x     = xv;
        start = 1'b1;
        for (int cyc = 1; cyc <= 40 && !fin; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            stop  = 1'b0;
            x     = ~xv;
            if (valid) begin
                chk("cnt_seq", 32'(cnt), nvalid);
                for (int k = 0; k < NC; k++) begin
                    pat[k][cnt] = sn[k];
                    ones[k]    += int'(sn[k]);
                end
                nvalid++;
                if (stop_at >= 0 && 32'(cnt) == stop_at) stop = 1'b1;
            end else begin
                if (done) begin
                    ndone++;
                    done_at = cyc;
                end
                chk("idle_sn", 32'(sn), 0);
                chk("idle_busy", 32'(busy), 0);
                fin = 1'b1;
            end
        end
        if (!fin) chk("stream_timeout", 0, 1);
        @(negedge clk);
        chk("after_done", 32'(done), 0);
        chk("after_valid", 32'(valid), 0);
    endtask

    initial begin
        int vc, dc, on;
        int dcyc [3];
        bit found;

        rst   = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        x     = '0;
        #12;
        chk("rst_valid", 32'(valid), 0);
        chk("rst_busy",  32'(busy),  0);
        chk("rst_done",  32'(done),  0);
        chk("rst_sn",    32'(sn),    0);
        chk("rst_cnt",   32'(cnt),   0);
        @(negedge clk);
        rst = 1'b0;

        // x=1010 on channel 0
        run_stream({4'h0, 4'h0, 4'h0, 4'hA}, -1);
`ifndef SNG_LFSR_EN
        chk("a_pat0", 32'(pat[0]), 32'h5D5D);
`endif
        chk("a_ones0",  ones[0], 10);
        chk("a_nvalid", nvalid,  16);
        chk("a_ndone",  ndone,   1);
        chk("a_doneat", done_at, 17);

        // four channels: F, 0, 8, 1 (channel 3 down to 0)
        run_stream({4'hF, 4'h0, 4'h8, 4'h1}, -1);
        chk("b_ones3", ones[3], 15);
        chk("b_ones2", ones[2], 0);
        chk("b_ones1", ones[1], 8);
        chk("b_ones0", ones[0], 1);
`ifndef SNG_LFSR_EN
        chk("b_pat3", 32'(pat[3]), 32'h7FFF);
        chk("b_pat1", 32'(pat[1]), 32'h5555);
        chk("b_pat0", 32'(pat[0]), 32'h0080);
`endif

        // abort at c=5, then a full stream
        run_stream({4'h0, 4'h0, 4'h0, 4'hA}, 5);
        chk("s_nvalid", nvalid, 6);
        chk("s_ndone",  ndone,  0);
        run_stream({4'h0, 4'h0, 4'h0, 4'hA}, -1);
        chk("s2_nvalid", nvalid,  16);
        chk("s2_ones0",  ones[0], 10);
        chk("s2_ndone",  ndone,   1);

        // start held high: back-to-back streams with one DONE cycle between
        vc = 0; dc = 0; on = 0;
        dcyc[0] = -1; dcyc[1] = -1; dcyc[2] = -1;
        x     = 16'h0003;
        start = 1'b1;
        for (int cyc = 1; cyc <= 54; cyc++) begin
            @(negedge clk);
            if (valid) begin
                vc++;
                on += int'(sn[0]);
            end
            if (done) begin
                if (dc < 3) dcyc[dc] = cyc;
                dc++;
            end
            if (cyc == 51) start = 1'b0;
        end
        chk("h_valid", vc, 48);
        chk("h_done",  dc, 3);
        chk("h_ones",  on, 9);
        chk("h_d0",    dcyc[0], 17);
        chk("h_d1",    dcyc[1], 34);
        chk("h_d2",    dcyc[2], 51);
        chk("h_idle",  32'(valid), 0);

        // asynchronous reset mid-stream at c=9
        x     = {4'h0, 4'h0, 4'h0, 4'hA};
        start = 1'b1;
        found = 1'b0;
        for (int cyc = 1; cyc <= 20 && !found; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (valid && cnt == 4'd9) found = 1'b1;
        end
        chk("r_reach9", 32'(found), 1);
        rst = 1'b1;
        #1;
        chk("r_valid", 32'(valid), 0);
        chk("r_sn",    32'(sn),    0);
        chk("r_cnt",   32'(cnt),   0);
        chk("r_busy",  32'(busy),  0);
        chk("r_done",  32'(done),  0);
        @(negedge clk);
        rst = 1'b0;
        vc = 0; dc = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            if (valid) vc++;
            if (done) dc++;
        end
        chk("r_post_valid", vc, 0);
        chk("r_post_done",  dc, 0);

        // start and stop together in IDLE
        x     = 16'hFFFF;
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        chk("ss_valid", 32'(valid), 0);
        chk("ss_busy",  32'(busy),  0);
        @(negedge clk);
        chk("ss_valid2", 32'(valid), 0);

        // final stream with mixed operands 2, 4, 7, C
        run_stream({4'h2, 4'h4, 4'h7, 4'hC}, -1);
        chk("f_ones3", ones[3], 2);
        chk("f_ones2", ones[2], 4);
        chk("f_ones1", ones[1], 7);
        chk("f_ones0", ones[0], 12);
`ifndef SNG_LFSR_EN
        chk("f_pat0", 32'(pat[0]), 32'h7777);
`endif
        chk("f_ndone", ndone, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
